// File: rtl/if_fetch_unit.sv
// if_fetch_unit: MIPS IF stage; walks the PC, fetches from imem with one request in flight, buffers words, presents pc/inst to IF/ID
module if_fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        be_i,
    input  logic [31:0] baddr_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        valid_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t        state, state_n;
    logic          live;
    logic [31:0]   fetch_pc, fetch_pc_n;
    logic [31:0]   target_q, target_n;
    logic [31:0]   tgt;
    logic [31:0]   q_pc   [DEPTH];
    logic [31:0]   q_inst [DEPTH];
    logic [PW-1:0] head, tail;
    logic [PW:0]   count;
    logic          push, pop;

    assign tgt         = baddr_i & ~32'd3;
    assign pop         = !stall_i && !be_i && count != '0;
    assign imem_addr_o = fetch_pc;

    // Request gating and next fetch address; a redirect against an unacked request parks in DRAIN until the ack lands
    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        target_n   = target_q;
        imem_req_o = 1'b0;
        push       = 1'b0;
        if (state == RUN) begin
            imem_req_o = live && (count < FULL || pop);
            if (be_i) begin
                if (imem_req_o && !imem_ack_i) begin
                    state_n  = DRAIN;
                    target_n = tgt;
                end else begin
                    fetch_pc_n = tgt;
                end
            end else if (imem_req_o && imem_ack_i) begin
                push       = 1'b1;
                fetch_pc_n = fetch_pc + 32'd4;
            end
        end else begin
            imem_req_o = 1'b1;
            target_n   = be_i ? tgt : target_q;
            if (imem_ack_i) begin
                state_n    = RUN;
                fetch_pc_n = target_n;
            end
        end
    end

    // FSM state, fetch pointer and queue occupancy; live holds off requests for the first cycle out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            live     <= 1'b0;
            fetch_pc <= RESET_PC;
            target_q <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            state    <= state_n;
            live     <= 1'b1;
            fetch_pc <= fetch_pc_n;
            target_q <= target_n;
            if (be_i) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + PW'(1);
                if (pop) head <= head + PW'(1);
                count <= count + (PW+1)'(push) - (PW+1)'(pop);
            end
        end
    end

    // Prefetch storage; contents are don't-care while the slot is not counted
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[tail]   <= fetch_pc;
            q_inst[tail] <= imem_rdata_i;
        end
    end

    // IF/ID output register: redirect forces a bubble, stall holds, otherwise pop head or bubble when empty
    always_ff @(posedge clk) begin
        if (rst || be_i) begin
            pc_o    <= '0;
            inst_o  <= '0;
            valid_o <= 1'b0;
        end else if (!stall_i) begin
            pc_o    <= pop ? q_pc[head] : '0;
            inst_o  <= pop ? q_inst[head] : '0;
            valid_o <= pop;
        end
    end

    // Request gating must make a push into a full queue without a pop impossible
    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && count == FULL && !pop));
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: scoreboard bench for the fetch unit against a latency-configurable memory model
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        be_i = 1'b0;
    logic [31:0] baddr_i = '0;
    logic        stall_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] pc_o, inst_o;
    logic        valid_o;

    int checks = 0;
    int passed = 0;
    int lat = 0;
    int wcnt = 0;
    logic [31:0] sb[$];
    logic [31:0] exp_fetch = '0;
    logic [31:0] mon_e;
    logic        draining = 1'b0;
    logic        upd = 1'b0;
    logic        upd_be = 1'b0;
    logic        ack_seen = 1'b0;

    if_fetch_unit #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .be_i(be_i), .baddr_i(baddr_i), .stall_i(stall_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
        .imem_rdata_i(imem_rdata_i), .pc_o(pc_o), .inst_o(inst_o), .valid_o(valid_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        upd    <= !rst && !stall_i && !be_i;
        upd_be <= !rst && be_i;
    end

    always @(negedge clk) begin
        if (upd_be) begin
            checks++;
            if (valid_o !== 1'b0 || pc_o !== 32'h0 || inst_o !== 32'h0)
                $display("FAIL redirect_bubble: valid=%b pc=%h inst=%h, want 0/0/0", valid_o, pc_o, inst_o);
            else passed++;
        end else if (upd && valid_o === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL out_unexpected: pc=%h inst=%h with nothing expected", pc_o, inst_o);
            end else begin
                mon_e = sb.pop_front();
                if (pc_o !== mon_e || inst_o !== (mon_e | 32'h2000_0000))
                    $display("FAIL out_order: pc=%h inst=%h, want pc=%h inst=%h", pc_o, inst_o, mon_e, mon_e | 32'h2000_0000);
                else passed++;
            end
        end
        if (rst) begin
            imem_ack_i = 1'b0;
            wcnt = 0;
            sb.delete();
            exp_fetch = 32'h0;
            draining = 1'b0;
        end else if (imem_req_o) begin
            if (wcnt >= lat) begin
                imem_ack_i = 1'b1;
                imem_rdata_i = imem_addr_o | 32'h2000_0000;
                wcnt = 0;
                ack_seen = 1'b1;
                if (be_i) begin
                    sb.delete();
                    exp_fetch = baddr_i & ~32'd3;
                    draining = 1'b0;
                end else if (draining) begin
                    draining = 1'b0;
                end else begin
                    checks++;
                    if (imem_addr_o !== exp_fetch)
                        $display("FAIL fetch_addr: got %h, want %h", imem_addr_o, exp_fetch);
                    else passed++;
                    sb.push_back(exp_fetch);
                    exp_fetch = exp_fetch + 32'd4;
                end
            end else begin
                imem_ack_i = 1'b0;
                wcnt++;
                if (be_i) begin
                    sb.delete();
                    exp_fetch = baddr_i & ~32'd3;
                    draining = 1'b1;
                end
            end
        end else begin
            imem_ack_i = 1'b0;
            wcnt = 0;
            if (be_i) begin
                sb.delete();
                exp_fetch = baddr_i & ~32'd3;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        be_i = 1'b0;
        stall_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h0 || pc_o !== 32'h0 || inst_o !== 32'h0 || valid_o !== 1'b0)
            $display("FAIL reset_state: req=%b addr=%h pc=%h inst=%h valid=%b, want all 0", imem_req_o, imem_addr_o, pc_o, inst_o, valid_o);
        else passed++;
    endtask

    task automatic test_stream;
        lat = 0;
        rst = 1'b0;
        checks++;
        if (imem_req_o !== 1'b0) $display("FAIL post_reset_idle: req=%b, want 0", imem_req_o); else passed++;
        tick();
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) $display("FAIL first_req: req=%b addr=%h, want 1/0", imem_req_o, imem_addr_o); else passed++;
        tick();
        checks++;
        if (imem_addr_o !== 32'h4 || valid_o !== 1'b0) $display("FAIL stream_c: addr=%h valid=%b, want 4/0", imem_addr_o, valid_o); else passed++;
        tick();
        checks++;
        if (imem_addr_o !== 32'h8 || valid_o !== 1'b1 || pc_o !== 32'h0) $display("FAIL stream_d: addr=%h valid=%b pc=%h, want 8/1/0", imem_addr_o, valid_o, pc_o); else passed++;
        tick();
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h4) $display("FAIL stream_e: valid=%b pc=%h, want 1/4", valid_o, pc_o); else passed++;
        tick();
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h8 || inst_o !== 32'h2000_0008) $display("FAIL stream_f: valid=%b pc=%h inst=%h, want 1/8/20000008", valid_o, pc_o, inst_o); else passed++;
    endtask

    task automatic test_stall;
        logic [31:0] hpc, hinst;
        logic hv;
        tick();
        tick();
        stall_i = 1'b1;
        hpc = pc_o;
        hinst = inst_o;
        hv = valid_o;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (pc_o !== hpc || inst_o !== hinst || valid_o !== hv)
                $display("FAIL stall_hold: pc=%h inst=%h valid=%b, want %h/%h/%b", pc_o, inst_o, valid_o, hpc, hinst, hv);
            else passed++;
        end
        checks++;
        if (imem_req_o !== 1'b0) $display("FAIL stall_full_req: req=%b, want 0", imem_req_o); else passed++;
        stall_i = 1'b0;
        #1;
        checks++;
        if (imem_req_o !== 1'b1) $display("FAIL stall_release_req: req=%b, want 1", imem_req_o); else passed++;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_redirect_idle;
        int n = 0;
        stall_i = 1'b1;
        tick();
        while (imem_req_o !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (imem_req_o !== 1'b0) $display("FAIL idle_wait: req=%b, want 0 within budget", imem_req_o); else passed++;
        be_i = 1'b1;
        baddr_i = 32'h0000_0103;
        tick();
        be_i = 1'b0;
        stall_i = 1'b0;
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0000_0100)
            $display("FAIL redirect_addr: req=%b addr=%h, want 1/00000100", imem_req_o, imem_addr_o);
        else passed++;
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_drain;
        int n = 0;
        do_reset();
        lat = 2;
        while (!(imem_req_o === 1'b1 && imem_addr_o === 32'h10) && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (imem_addr_o !== 32'h10 || imem_req_o !== 1'b1) $display("FAIL drain_reach: req=%b addr=%h, want 1/10", imem_req_o, imem_addr_o); else passed++;
        be_i = 1'b1;
        baddr_i = 32'h40;
        tick();
        be_i = 1'b0;
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10) $display("FAIL drain_hold: req=%b addr=%h, want 1/10", imem_req_o, imem_addr_o); else passed++;
        ack_seen = 1'b0;
        n = 0;
        while (imem_addr_o === 32'h10 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (imem_addr_o !== 32'h40 || ack_seen !== 1'b1) $display("FAIL drain_exit: addr=%h acked=%b, want 40/1", imem_addr_o, ack_seen); else passed++;
        n = 0;
        while (valid_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h40) $display("FAIL drain_first_out: valid=%b pc=%h, want 1/40", valid_o, pc_o); else passed++;
    endtask

    task automatic test_wrap;
        int n = 0;
        lat = 0;
        for (int i = 0; i < 4; i++) tick();
        be_i = 1'b1;
        baddr_i = 32'hFFFF_FFFE;
        tick();
        be_i = 1'b0;
        while (imem_addr_o !== 32'hFFFF_FFFC && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (imem_addr_o !== 32'hFFFF_FFFC) $display("FAIL wrap_target: addr=%h, want fffffffc", imem_addr_o); else passed++;
        tick();
        checks++;
        if (imem_addr_o !== 32'h0) $display("FAIL wrap_next: addr=%h, want 00000000", imem_addr_o); else passed++;
        for (int i = 0; i < 5; i++) tick();
    endtask

    task automatic test_reset_pending;
        int n = 0;
        lat = 2;
        while (!(imem_req_o === 1'b1 && wcnt == 1) && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (imem_req_o !== 1'b1 || wcnt != 1) $display("FAIL pend_reach: req=%b wait=%0d, want 1/1", imem_req_o, wcnt); else passed++;
        rst = 1'b1;
        tick();
        checks++;
        if (imem_req_o !== 1'b0 || valid_o !== 1'b0 || imem_addr_o !== 32'h0)
            $display("FAIL rst_pending: req=%b valid=%b addr=%h, want 0/0/0", imem_req_o, valid_o, imem_addr_o);
        else passed++;
        rst = 1'b0;
        n = 0;
        while (imem_req_o !== 1'b1 && n < 5) begin
            tick();
            n++;
        end
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) $display("FAIL rst_first_req: req=%b addr=%h, want 1/0", imem_req_o, imem_addr_o); else passed++;
        for (int i = 0; i < 15; i++) tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_idle();
        test_drain();
        test_wrap();
        test_reset_pending();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
